// File: rtl/screen_writer_if.sv
// Screen writer bus bundle: command handshake from game logic, write port and
// second read port of the dual-port tile screen RAM, and status pulses.
//   master : game logic + RAM side (drives commands and rd_data)
//   slave  : screen_writer (accepts commands, drives RAM write/read addresses)
interface screen_writer_if #(
  parameter int ADDR_W = 11,
  parameter int CHAR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        cmd_x;
  logic [4:0]        cmd_y;
  logic [CHAR_W-1:0] cmd_char;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [CHAR_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_char, rd_data,
    input  cmd_ready, wr_en, wr_addr, wr_data, rd_addr, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_char, rd_data,
    output cmd_ready, wr_en, wr_addr, wr_data, rd_addr, busy, done, err
  );
endinterface

// File: rtl/screen_writer.sv
// Write-side agent for the 40x30 tile screen memory.
// Accepts PUT / CLEAR / SCROLL commands over a valid/ready handshake and drives
// the write port of the screen RAM; SCROLL also uses a second read port.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : screen_writer_if.slave (command handshake, RAM write/read port,
//           busy / done / err status)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a command; PUT writes land the cycle after accept
// CLEAR   | writing the latched fill code, addresses 1199 down to 0
// SCR_RD  | reading d-COLS for d = 1199..40; copy write follows 1 cycle later
// SCR_TOP | last copy write (addr 40), then fill for addresses 39 down to 0
module screen_writer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 11,
  parameter int CHAR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  screen_writer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, SCR_RD, SCR_TOP} state_e;

  localparam logic [1:0] OP_PUT    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SCROLL = 2'b10;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_SRC  = ADDR_W'(COLS*ROWS - 1 - COLS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CHAR_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CHAR_W-1:0] fill_q, fill_d;
  logic              copy_q, copy_d;

  logic              cmd_ready;
  logic              accept;
  logic              put_ok;
  logic [ADDR_W-1:0] put_addr;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign put_ok    = (bus.cmd_x < 6'(COLS)) && (bus.cmd_y < 5'(ROWS));
  assign put_addr  = ADDR_W'(bus.cmd_y) * COLS_A + ADDR_W'(bus.cmd_x);

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fill_d    = fill_q;
    copy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_PUT: begin
              if (put_ok) begin
                wr_en_d   = 1'b1;
                wr_addr_d = put_addr;
                wr_data_d = bus.cmd_char;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              state_d   = CLEAR;
              busy_d    = 1'b1;
              fill_d    = bus.cmd_char;
              wr_en_d   = 1'b1;
              wr_addr_d = LAST_ADDR;
              wr_data_d = bus.cmd_char;
            end
            OP_SCROLL: begin
              state_d   = SCR_RD;
              busy_d    = 1'b1;
              fill_d    = bus.cmd_char;
              rd_addr_d = LAST_SRC;
            end
            default: ;
          endcase
        end
      end
      SCR_RD: begin
        // schedule the copy of the word being read now; it arrives next cycle
        wr_en_d   = 1'b1;
        copy_d    = 1'b1;
        wr_addr_d = rd_addr_q + COLS_A;
        if (rd_addr_q == '0) state_d = SCR_TOP;
        else                 rd_addr_d = rd_addr_q - ONE_A;
      end
      CLEAR, SCR_TOP: begin
        // wr_addr_q is the address being written this cycle
        if (wr_addr_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q - ONE_A;
          wr_data_d = fill_q;
          done_d    = (wr_addr_q == ONE_A);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fill_q    <= '0;
      copy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fill_q    <= fill_d;
      copy_q    <= copy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  // Copy writes forward the RAM read data straight through: the read port
  // already spends one register stage, which keeps writes exactly one cycle
  // behind their reads. Every other write uses the registered data.
  assign bus.wr_data   = copy_q ? bus.rd_data : wr_data_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_screen_writer.sv
module tb_screen_writer;

  localparam logic [1:0] OP_PUT    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SCROLL = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic preload;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  logic [2:0] mem     [0:2047];
  logic [2:0] exp_old [0:1199];

  screen_writer_if #(.ADDR_W(11), .CHAR_W(3)) bus ();

  screen_writer #(.COLS(40), .ROWS(30), .ADDR_W(11), .CHAR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // dual-port RAM model: registered read, one write port
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 1200; a++) mem[a] <= 3'(a % 8);
    end else if (bus.wr_en === 1'b1) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    bus.rd_data <= mem[bus.rd_addr];
  end

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] x,
                       input logic [4:0] y, input logic [2:0] c);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_char  = c;
  endtask

  // Called in the first SCR_RD cycle; walks 1201 busy cycles against exp_old.
  task automatic run_scroll(input logic [2:0] fill, output int e_rd, output int e_wr,
                            output int e_done, output int e_busy);
    logic [2:0] exp_d;
    e_rd = 0; e_wr = 0; e_done = 0; e_busy = 0;
    for (int k = 0; k <= 1200; k++) begin
      if (k <= 1159 && bus.rd_addr !== 11'(1159 - k)) e_rd++;
      if (k == 0) begin
        if (bus.wr_en !== 1'b0) e_wr++;
      end else begin
        exp_d = (k <= 1160) ? exp_old[1160 - k] : fill;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'(1200 - k) || bus.wr_data !== exp_d) e_wr++;
      end
      if (bus.done !== (k == 1200)) e_done++;
      if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) e_busy++;
      tick();
    end
  endtask

  initial begin
    int w0, d0, bad, bad_done, ready_low;
    int e_rd, e_wr, e_done, e_busy;
    logic [2:0] exp_m;

    reset   = 1'b1;
    preload = 1'b0;
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    repeat (3) tick();
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(bus.cmd_ready), 1);

    // PUT x=5 y=2 -> 85
    drive(1'b1, OP_PUT, 6'd5, 5'd2, 3'd3);
    tick();
    chk("put_wr_en", 32'(bus.wr_en), 1);
    chk("put_addr", 32'(bus.wr_addr), 85);
    chk("put_data", 32'(bus.wr_data), 3);
    chk("put_err", 32'(bus.err), 0);
    chk("put_ready", 32'(bus.cmd_ready), 1);
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    tick();
    chk("put_idle_wr_en", 32'(bus.wr_en), 0);

    // out-of-range PUTs back to back, then the corner tile
    drive(1'b1, OP_PUT, 6'd40, 5'd0, 3'd1);
    tick();
    chk("badx_wr_en", 32'(bus.wr_en), 0);
    chk("badx_err", 32'(bus.err), 1);
    drive(1'b1, OP_PUT, 6'd0, 5'd30, 3'd2);
    tick();
    chk("bady_wr_en", 32'(bus.wr_en), 0);
    chk("bady_err", 32'(bus.err), 1);
    drive(1'b1, OP_PUT, 6'd39, 5'd29, 3'd5);
    tick();
    chk("max_wr_en", 32'(bus.wr_en), 1);
    chk("max_addr", 32'(bus.wr_addr), 1199);
    chk("max_data", 32'(bus.wr_data), 5);
    chk("max_err", 32'(bus.err), 0);
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    tick();
    chk("after_put_err", 32'(bus.err), 0);

    // CLEAR with fill 0
    w0 = wr_cnt; d0 = done_cnt;
    drive(1'b1, OP_CLEAR, 6'd0, 5'd0, 3'd0);
    tick();
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    bad = 0; bad_done = 0; ready_low = 0;
    for (int i = 0; i < 1200; i++) begin
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'(1199 - i) || bus.wr_data !== 3'd0 ||
          bus.busy !== 1'b1) bad++;
      if (bus.done !== (i == 1199)) bad_done++;
      if (bus.cmd_ready === 1'b0) ready_low++;
      tick();
    end
    chk("clr_seq_errors", 32'(bad), 0);
    chk("clr_done_errors", 32'(bad_done), 0);
    chk("clr_ready_low_cycles", 32'(ready_low), 1200);
    chk("clr_busy_after", 32'(bus.busy), 0);
    chk("clr_ready_after", 32'(bus.cmd_ready), 1);
    chk("clr_wr_en_after", 32'(bus.wr_en), 0);
    chk("clr_write_count", 32'(wr_cnt - w0), 1200);
    chk("clr_done_count", 32'(done_cnt - d0), 1);

    // SCROLL fill 4 over mem[a] = a%8
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int a = 0; a < 1200; a++) exp_old[a] = 3'(a % 8);
    w0 = wr_cnt; d0 = done_cnt;
    drive(1'b1, OP_SCROLL, 6'd0, 5'd0, 3'd4);
    tick();
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    run_scroll(3'd4, e_rd, e_wr, e_done, e_busy);
    chk("scr_rd_errors", 32'(e_rd), 0);
    chk("scr_wr_errors", 32'(e_wr), 0);
    chk("scr_done_errors", 32'(e_done), 0);
    chk("scr_busy_errors", 32'(e_busy), 0);
    chk("scr_busy_after", 32'(bus.busy), 0);
    chk("scr_ready_after", 32'(bus.cmd_ready), 1);
    chk("scr_write_count", 32'(wr_cnt - w0), 1200);
    chk("scr_done_count", 32'(done_cnt - d0), 1);
    bad = 0;
    for (int a = 0; a < 1200; a++) begin
      exp_m = (a >= 40) ? 3'((a - 40) % 8) : 3'd4;
      if (mem[a] !== exp_m) bad++;
    end
    chk("scr_mem_errors", 32'(bad), 0);

    // reset in the middle of a CLEAR
    drive(1'b1, OP_CLEAR, 6'd0, 5'd0, 3'd7);
    tick();
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    repeat (499) tick();
    chk("abort_write500_addr", 32'(bus.wr_addr), 700);
    reset = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    tick();
    chk("abort_wr_en", 32'(bus.wr_en), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_wr_addr", 32'(bus.wr_addr), 0);
    chk("abort_ready_in_reset", 32'(bus.cmd_ready), 0);
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.cmd_ready), 1);
    tick();
    tick();
    chk("abort_no_writes", 32'(wr_cnt - w0), 0);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    drive(1'b1, OP_PUT, 6'd7, 5'd3, 3'd6);
    tick();
    chk("abort_put_wr_en", 32'(bus.wr_en), 1);
    chk("abort_put_addr", 32'(bus.wr_addr), 127);
    chk("abort_put_data", 32'(bus.wr_data), 6);
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    tick();

    // PUT then SCROLL on the next cycle, command held while busy
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int a = 0; a < 1200; a++) exp_old[a] = 3'(a % 8);
    drive(1'b1, OP_PUT, 6'd1, 5'd1, 3'd2);
    tick();
    chk("bb_put_wr_en", 32'(bus.wr_en), 1);
    chk("bb_put_addr", 32'(bus.wr_addr), 41);
    exp_old[41] = 3'd2;
    drive(1'b1, OP_SCROLL, 6'd0, 5'd0, 3'd3);
    chk("bb_scroll_ready", 32'(bus.cmd_ready), 1);
    tick();
    drive(1'b1, OP_PUT, 6'd3, 5'd0, 3'd5);
    w0 = wr_cnt;
    run_scroll(3'd3, e_rd, e_wr, e_done, e_busy);
    chk("bb_rd_errors", 32'(e_rd), 0);
    chk("bb_wr_errors", 32'(e_wr), 0);
    chk("bb_done_errors", 32'(e_done), 0);
    chk("bb_busy_errors", 32'(e_busy), 0);
    chk("bb_write_count", 32'(wr_cnt - w0), 1200);
    chk("bb_ready_after", 32'(bus.cmd_ready), 1);
    tick();
    chk("bb_held_put_wr_en", 32'(bus.wr_en), 1);
    chk("bb_held_put_addr", 32'(bus.wr_addr), 3);
    chk("bb_held_put_data", 32'(bus.wr_data), 5);
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    tick();
    chk("bb_mem81_from_put", 32'(mem[81]), 2);
    chk("bb_mem41_copied", 32'(mem[41]), 1);
    chk("bb_mem3_held_put", 32'(mem[3]), 5);
    bad = 0;
    for (int a = 0; a < 1200; a++) begin
      exp_m = (a >= 40) ? exp_old[a - 40] : ((a == 3) ? 3'd5 : 3'd3);
      if (mem[a] !== exp_m) bad++;
    end
    chk("bb_mem_errors", 32'(bad), 0);

    // reserved op consumed with no effect
    w0 = wr_cnt;
    drive(1'b1, OP_RSVD, 6'd2, 5'd2, 3'd6);
    tick();
    chk("rsvd_wr_en", 32'(bus.wr_en), 0);
    chk("rsvd_err", 32'(bus.err), 0);
    chk("rsvd_busy", 32'(bus.busy), 0);
    drive(1'b0, OP_PUT, 6'd0, 5'd0, 3'd0);
    tick();
    chk("rsvd_no_writes", 32'(wr_cnt - w0), 0);
    chk("rsvd_ready", 32'(bus.cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
